// File: rtl/screen_rom_reader_if.sv
// Read bus between the screen image reader and the 471x250 image ROM.
// The reader drives the address; the ROM returns data one clock later.
interface screen_rom_reader_if;
  logic [16:0] addr;
  logic [7:0]  rom_data;

  modport master (output addr, input rom_data);
  modport slave  (input addr, output rom_data);
endinterface

// File: rtl/screen_rom_reader.sv
// Maps VGA pixel coordinates into the screen image ROM, compensates the ROM
// read latency and gates the result with a top-to-bottom reveal wipe.
// Coordinate in to pixel out is a fixed 3-clock pipeline.
module screen_rom_reader #(
  parameter int          IMG_W       = 471,
  parameter int          IMG_H       = 250,
  parameter int          X0          = 84,
  parameter int          Y0          = 115,
  parameter int          REVEAL_STEP = 10,
  parameter logic [7:0]  BG_COLOR    = 8'h00
) (
  input  logic                       i_clk2,
  input  logic                       i_rst_n,
  input  logic [9:0]                 i_x,
  input  logic [9:0]                 i_y,
  input  logic                       i_active,
  input  logic                       i_frame_tick,
  input  logic                       i_show,
  screen_rom_reader_if.master        rom,
  output logic [7:0]                 o_pixel,
  output logic                       o_valid,
  output logic                       o_active,
  output logic                       o_busy
);

  localparam logic [1:0] HIDDEN = 2'd0;
  localparam logic [1:0] REVEAL = 2'd1;
  localparam logic [1:0] SHOWN  = 2'd2;

  localparam logic [10:0] X_LO = 11'(X0);
  localparam logic [10:0] X_HI = 11'(X0 + IMG_W);
  localparam logic [10:0] Y_LO = 11'(Y0);
  localparam logic [10:0] Y_HI = 11'(Y0 + IMG_H);
  localparam logic [8:0]  ROWS_FULL = 9'(IMG_H);

  // Saturating advance of the revealed row count; never exceeds the image height.
  function automatic logic [8:0] sat_rows(input logic [8:0] r);
    logic [10:0] s;
    s = 11'(r) + 11'(REVEAL_STEP);
    if (s > 11'(IMG_H)) return ROWS_FULL;
    return s[8:0];
  endfunction

  logic [1:0]  state_q, state_d;
  logic [8:0]  reveal_rows_q, reveal_rows_d;

  logic [16:0] addr_q, addr_d;
  logic        win_p1_q, win_p1_d, rev_p1_q, rev_p1_d, act_p1_q, act_p1_d;
  logic        win_p2_q, win_p2_d, rev_p2_q, rev_p2_d, act_p2_q, act_p2_d;
  logic [7:0]  pixel_q, pixel_d;
  logic        valid_q, valid_d, active_q, active_d;

  logic        in_win;
  logic [9:0]  row, col;

  // Reveal wipe control: row count only moves on a frame tick or a hide.
  always_comb begin
    state_d       = state_q;
    reveal_rows_d = reveal_rows_q;
    case (state_q)
      HIDDEN: begin
        reveal_rows_d = '0;
        if (i_show) state_d = REVEAL;
      end
      REVEAL: begin
        if (!i_show) begin
          state_d       = HIDDEN;
          reveal_rows_d = '0;
        end else if (i_frame_tick) begin
          reveal_rows_d = sat_rows(reveal_rows_q);
          if (reveal_rows_d == ROWS_FULL) state_d = SHOWN;
        end
      end
      SHOWN: begin
        reveal_rows_d = ROWS_FULL;
        if (!i_show) begin
          state_d       = HIDDEN;
          reveal_rows_d = '0;
        end
      end
      default: begin
        state_d       = HIDDEN;
        reveal_rows_d = '0;
      end
    endcase
  end

  // Pixel pipeline: window test and address, ROM wait, then output select.
  always_comb begin
    // stage 0: window test and image-relative coordinates
    in_win = i_active &&
             ({1'b0, i_x} >= X_LO) && ({1'b0, i_x} < X_HI) &&
             ({1'b0, i_y} >= Y_LO) && ({1'b0, i_y} < Y_HI);
    row = i_y - 10'(Y0);
    col = i_x - 10'(X0);

    // stage 1: ROM address (held outside the window) and flags
    addr_d   = in_win ? (17'(row) * 17'(IMG_W) + 17'(col)) : addr_q;
    win_p1_d = in_win;
    rev_p1_d = (row < {1'b0, reveal_rows_q});
    act_p1_d = i_active;

    // stage 2: flags wait alongside the ROM read
    win_p2_d = win_p1_q;
    rev_p2_d = rev_p1_q;
    act_p2_d = act_p1_q;

    // stage 3: ROM data or background
    valid_d  = win_p2_q && rev_p2_q;
    pixel_d  = valid_d ? rom.rom_data : BG_COLOR;
    active_d = act_p2_q;
  end

  // State and pipeline registers, cleared asynchronously.
  always_ff @(posedge i_clk2 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= HIDDEN;
      reveal_rows_q <= '0;
      addr_q        <= '0;
      win_p1_q      <= 1'b0;
      rev_p1_q      <= 1'b0;
      act_p1_q      <= 1'b0;
      win_p2_q      <= 1'b0;
      rev_p2_q      <= 1'b0;
      act_p2_q      <= 1'b0;
      pixel_q       <= BG_COLOR;
      valid_q       <= 1'b0;
      active_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      reveal_rows_q <= reveal_rows_d;
      addr_q        <= addr_d;
      win_p1_q      <= win_p1_d;
      rev_p1_q      <= rev_p1_d;
      act_p1_q      <= act_p1_d;
      win_p2_q      <= win_p2_d;
      rev_p2_q      <= rev_p2_d;
      act_p2_q      <= act_p2_d;
      pixel_q       <= pixel_d;
      valid_q       <= valid_d;
      active_q      <= active_d;
    end
  end

  assign rom.addr = addr_q;
  assign o_pixel  = pixel_q;
  assign o_valid  = valid_q;
  assign o_active = active_q;
  assign o_busy   = (state_q == REVEAL);

endmodule

// File: tb/tb_screen_rom_reader.sv
// Directed bench for screen_rom_reader: reset, address mapping, latency,
// reveal wipe, saturation (second instance with a 40-row step) and hide priority.
module tb_screen_rom_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] i_x, i_y;
  logic       i_active, i_frame_tick, i_show;

  logic [7:0] pix1, pix2;
  logic       vld1, vld2, act1, act2, busy1, busy2;

  int checks   = 0;
  int failures = 0;

  screen_rom_reader_if rom1 ();
  screen_rom_reader_if rom2 ();

  screen_rom_reader dut1 (
    .i_clk2(clk), .i_rst_n(rst_n), .i_x(i_x), .i_y(i_y), .i_active(i_active),
    .i_frame_tick(i_frame_tick), .i_show(i_show), .rom(rom1.master),
    .o_pixel(pix1), .o_valid(vld1), .o_active(act1), .o_busy(busy1)
  );

  screen_rom_reader #(.REVEAL_STEP(40)) dut2 (
    .i_clk2(clk), .i_rst_n(rst_n), .i_x(i_x), .i_y(i_y), .i_active(i_active),
    .i_frame_tick(i_frame_tick), .i_show(i_show), .rom(rom2.master),
    .o_pixel(pix2), .o_valid(vld2), .o_active(act2), .o_busy(busy2)
  );

  always #5 clk = ~clk;

  // ROM models: registered read returning the low address byte.
  always @(posedge clk) begin
    rom1.rom_data <= rom1.addr[7:0];
    rom2.rom_data <= rom2.addr[7:0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic a);
    i_x = x; i_y = y; i_active = a;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(10'd0, 10'd0, 1'b0);
  endtask

  task automatic tick();
    i_frame_tick = 1'b1;
    idle();
    i_frame_tick = 1'b0;
  endtask

  // One coordinate through dut1: address after 1 clock, nothing at 2, result at 3.
  task automatic point(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic [16:0] eaddr, input logic [7:0] epix, input logic evld);
    drive(x, y, 1'b1);
    chk({tag, "_addr"}, 32'(rom1.addr), 32'(eaddr));
    idle();
    chk({tag, "_early"}, 32'(vld1), 32'd0);
    idle();
    chk({tag, "_pix"}, 32'(pix1), 32'(epix));
    chk({tag, "_vld"}, 32'(vld1), 32'(evld));
    chk({tag, "_act"}, 32'(act1), 32'd1);
  endtask

  initial begin
    logic [7:0] ep [0:11];
    logic       ev [0:11];
    logic       ea [0:11];
    logic [9:0] xx;
    logic       aa;

    rst_n = 1'b0; i_frame_tick = 1'b0; i_show = 1'b0;
    i_x = '0; i_y = '0; i_active = 1'b0;

    // Reset held while in-window pixels stream in.
    for (int k = 0; k < 4; k++) drive(10'd84 + 10'(k), 10'd115, 1'b1);
    chk("rst_pix", 32'(pix1), 32'h00);
    chk("rst_vld", 32'(vld1), 32'd0);
    chk("rst_addr", 32'(rom1.addr), 32'd0);
    chk("rst_act", 32'(act1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    rst_n = 1'b1;
    idle(); idle(); idle();
    chk("hidden_state", 32'(dut1.state_q), 32'd0);

    // Show request coinciding with a tick: enters REVEAL, no rows yet.
    i_show = 1'b1;
    tick();
    chk("show_tick_state", 32'(dut1.state_q), 32'd1);
    chk("show_tick_rows", 32'(dut1.reveal_rows_q), 32'd0);

    for (int t = 1; t <= 25; t++) begin
      tick();
      idle();
      if (t == 3) begin
        chk("wipe3_rows", 32'(dut1.reveal_rows_q), 32'd30);
        chk("wipe3_busy", 32'(busy1), 32'd1);
        drive(10'd84, 10'd144, 1'b1);
        drive(10'd84, 10'd145, 1'b1);
        idle();
        chk("wipe3_row144_vld", 32'(vld1), 32'd1);
        chk("wipe3_row144_pix", 32'(pix1), 32'd91);
        idle();
        chk("wipe3_row145_vld", 32'(vld1), 32'd0);
        chk("wipe3_row145_pix", 32'(pix1), 32'h00);
      end
      if (t == 6) begin
        chk("sat6_rows", 32'(dut2.reveal_rows_q), 32'd240);
        chk("sat6_busy", 32'(busy2), 32'd1);
      end
      if (t == 7) begin
        chk("sat7_rows", 32'(dut2.reveal_rows_q), 32'd250);
        chk("sat7_state", 32'(dut2.state_q), 32'd2);
        chk("sat7_busy", 32'(busy2), 32'd0);
      end
      if (t == 24) chk("wipe24_busy", 32'(busy1), 32'd1);
    end
    chk("wipe25_rows", 32'(dut1.reveal_rows_q), 32'd250);
    chk("wipe25_state", 32'(dut1.state_q), 32'd2);
    chk("wipe25_busy", 32'(busy1), 32'd0);

    // Address mapping in SHOWN.
    point("tl",   10'd84,  10'd115, 17'd0,      8'd0,   1'b1);
    point("tr",   10'd554, 10'd115, 17'd470,    8'd214, 1'b1);
    point("row2", 10'd84,  10'd116, 17'd471,    8'd215, 1'b1);
    point("br",   10'd554, 10'd364, 17'd117749, 8'd245, 1'b1);
    point("xr",   10'd555, 10'd115, 17'd117749, 8'h00,  1'b0);
    point("xl",   10'd83,  10'd115, 17'd117749, 8'h00,  1'b0);

    // Sweep across the left edge of row 115 with one inactive gap.
    for (int k = 0; k < 12; k++) begin
      if (k < 10) begin
        xx = 10'd82 + 10'(k);
        aa = (xx != 10'd88);
        drive(xx, 10'd115, aa);
        ev[k] = aa && (xx >= 10'd84);
        ep[k] = ev[k] ? 8'(xx - 10'd84) : 8'h00;
        ea[k] = aa;
      end else begin
        idle();
      end
      if (k >= 2) begin
        chk($sformatf("sweep%0d_pix", k - 2), 32'(pix1), 32'(ep[k-2]));
        chk($sformatf("sweep%0d_vld", k - 2), 32'(vld1), 32'(ev[k-2]));
        chk($sformatf("sweep%0d_act", k - 2), 32'(act1), 32'(ea[k-2]));
      end
    end

    // Hide wins over a same-cycle frame tick during REVEAL.
    i_show = 1'b0; idle();
    i_show = 1'b1; idle();
    tick();
    chk("hp_rows10", 32'(dut1.reveal_rows_q), 32'd10);
    i_show = 1'b0;
    tick();
    chk("hp_state", 32'(dut1.state_q), 32'd0);
    chk("hp_rows", 32'(dut1.reveal_rows_q), 32'd0);
    chk("hp_busy", 32'(busy1), 32'd0);
    idle();
    point("hp_p0", 10'd84, 10'd115, 17'd0,   8'h00, 1'b0);
    point("hp_p1", 10'd84, 10'd116, 17'd471, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/screen_rom_reader.md
Name: screen_rom_reader

Overview:
- Read-side client of the 471x250 screen image ROM: 17-bit address in, 8-bit pixel out, registered read with one clock of latency.
- Sits between the VGA timing generator and the colour output mux.
- Maps each incoming pixel coordinate to a ROM address when the coordinate is inside the image window, and compensates for the ROM latency.
- Outputs an aligned 8-bit pixel and valid flag, and applies a top-to-bottom reveal wipe under a show/hide control.

Parameters:
- IMG_W, 471, image width in pixels
- IMG_H, 250, image height in pixels
- X0, 84, screen column of image left edge
- Y0, 115, screen row of image top edge
- REVEAL_STEP, 10, rows revealed per frame tick during the wipe
- BG_COLOR, 8'h00, pixel value driven when outside the window or masked

Ports:
- i_clk2  in  1  system/pixel clock, shared with the ROM
- i_rst_n  in  1  asynchronous active-low reset
- i_x  in  10  current screen column from the VGA timing generator
- i_y  in  10  current screen row from the VGA timing generator
- i_active  in  1  visible-area flag, aligned with i_x/i_y
- i_frame_tick  in  1  one-cycle pulse at start of vertical blank
- i_show  in  1  level: 1 = image requested visible
- o_addr  out  17  ROM address, to the ROM i_addr
- i_rom_data  in  8  ROM read data, from the ROM o_data, valid 1 cycle after o_addr
- o_pixel  out  8  output pixel
- o_valid  out  1  o_pixel lies inside the image window and the revealed region
- o_active  out  1  i_active delayed to align with o_pixel
- o_busy  out  1  reveal wipe in progress

Behaviour:
- Reset values (async, on i_rst_n low): o_addr=0, o_pixel=BG_COLOR, o_valid=0, o_active=0, o_busy=0, state=HIDDEN, reveal_rows=0, all pipeline flags=0.
- Stage 0 (cycle n):
  - in_win = i_active && X0<=i_x<X0+IMG_W && Y0<=i_y<Y0+IMG_H.
  - row = i_y-Y0; col = i_x-X0.
- Stage 1 (n+1):
  - o_addr <= in_win ? row*IMG_W+col : o_addr (address held when outside the window).
  - Register in_win, row<reveal_rows, and i_active.
  - Address arithmetic is unsigned, 17 bits. Maximum is 249*471+470 = 117749, with no wrap.
- Stage 2 (n+2): ROM data arrives; the flags shift one stage to stay aligned.
- Stage 3 (n+3):
  - o_pixel <= (win && revealed) ? i_rom_data : BG_COLOR.
  - o_valid <= win && revealed.
  - o_active <= active.
- Total latency from i_x/i_y/i_active to o_pixel/o_valid/o_active is 3 cycles, constant, independent of state.
- State machine, with transitions evaluated each clock:
  - HIDDEN: reveal_rows=0, o_busy=0. If i_show=1, go to REVEAL.
  - REVEAL: o_busy=1.
    - On i_frame_tick: reveal_rows <= min(reveal_rows+REVEAL_STEP, IMG_H) (saturating). When the new value equals IMG_H, go to SHOWN.
    - If i_show=0: go to HIDDEN and clear reveal_rows. This takes priority over a same-cycle frame tick.
  - SHOWN: reveal_rows=IMG_H, o_busy=0. If i_show=0, go to HIDDEN.
- reveal_rows is 9 bits wide and changes only on i_frame_tick or on a hide, so the image never tears mid-frame during the wipe. A hide takes effect from the next clock.
- i_show toggling high then low within one frame gives HIDDEN -> REVEAL -> HIDDEN, with no rows shown.
- If i_frame_tick coincides with the HIDDEN->REVEAL transition, it does not advance reveal_rows. The first increment uses the next tick.
- Async reset mid-frame clears the pipeline immediately; outputs stay at reset values until 3 clocks after reset release.

Test Plan:
- Reset: hold i_rst_n=0 while driving pixels -> o_pixel=8'h00, o_valid=0, o_addr=0. Release -> first valid output 3 cycles after the first in-window input.
- Address mapping, SHOWN state:
  - (x=84,y=115) -> o_addr=0.
  - (554,115) -> 470.
  - (84,116) -> 471.
  - (554,364) -> 117749.
  - (555,115) and (83,115) -> o_valid=0, o_pixel=BG_COLOR.
- Latency: ROM model returns the low address byte. Sweep row 115 -> o_pixel equals (col)&8'hFF exactly 3 cycles after each input; o_active mirrors i_active delayed by 3.
- Reveal wipe:
  - i_show=1, then 3 frame ticks -> reveal_rows=30. Rows 115..144 are valid, row 145 is not, o_busy=1.
  - After 25 ticks -> SHOWN, o_busy=0.
- Saturation: REVEAL_STEP=40 -> the 7th tick sets reveal_rows=250, not 280, and the state becomes SHOWN.
- Hide priority: in REVEAL, i_show=0 in the same cycle as i_frame_tick -> state HIDDEN, reveal_rows=0, o_valid=0 on all subsequent in-window pixels.
